vga_draw_arbiter: RTL and testbench
===================================

# vga_draw_arbiter

Sequences and shares the single VGA adapter pixel-write port among four symbol-drawing units and a full-screen clear engine. Each drawer presents one pixel per cycle while granted; the arbiter muxes and registers the selected pixel onto the adapter's plot/x/y/colour inputs. Grants are round-robin and are held for a whole symbol. A screen clear runs automatically after reset and on request.

## Interface
- CLEAR_COLOUR, 3'b000, colour written during a clear
- X_MAX, 160, screen width (x sweeps 0..X_MAX-1)
- Y_MAX, 120, screen height (y sweeps 0..Y_MAX-1)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- clear_req  in  1  request a full-screen clear (single-cycle pulse is sufficient)
- req  in  4  per-drawer draw request, held high until its last pixel is accepted
- px  in  32  drawer pixel x, drawer i on bits [8i+7:8i]
- py  in  28  drawer pixel y, drawer i on bits [7i+6:7i]
- pcolour  in  12  drawer pixel colour, drawer i on bits [3i+2:3i]
- plast  in  4  drawer i's current pixel is the final pixel of its symbol
- gnt  out  4  one-hot grant; drawer i advances to its next pixel on each clk edge where gnt[i]=1
- vga_x  out  8  registered pixel x to adapter
- vga_y  out  7  registered pixel y to adapter
- vga_colour  out  3  registered colour to adapter
- vga_plot  out  1  registered write enable to adapter
- busy  out  1  state != IDLE
- clearing  out  1  state == CLEAR

## Operation
- States: CLEAR, IDLE, GRANT. Reset enters CLEAR with cx=cy=0, rr_ptr=3, clear_pending=0.
- CLEAR: each cycle, register vga_x=cx, vga_y=cy, vga_colour=CLEAR_COLOUR, vga_plot=1. cx increments; on cx=X_MAX-1, cx wraps to 0 and cy increments. On (X_MAX-1, Y_MAX-1), go to IDLE and reset cx and cy to 0. The clear takes exactly X_MAX*Y_MAX plot cycles. gnt=0 throughout. A clear_req that arrives during CLEAR is ignored and does not restart the clear.
- IDLE: vga_plot=0 and gnt=0.
  - If clear_req or clear_pending is set, go to CLEAR and clear clear_pending. Clear has priority over draw requests.
  - Otherwise, if any req bit is set, pick the first set req searching rr_ptr+1, rr_ptr+2, ... (mod 4). Latch the winner as g and go to GRANT.
- GRANT: gnt = one-hot(g).
  - Each cycle, register vga_x=px[g], vga_y=py[g], vga_colour=pcolour[g], vga_plot=req[g].
  - If req[g] & plast[g]: go to IDLE and set rr_ptr=g.
  - If req[g]=0 (abort): vga_plot=0 that cycle, go to IDLE, and set rr_ptr=g.
- clear_req in IDLE or GRANT sets clear_pending. The clear is serviced at the next IDLE cycle, and an active grant is never interrupted.
- Requests from non-granted drawers are ignored until the grant is released. No drawer sees gnt without a request.

## Timing
- Reset values: vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, gnt=0, busy=1, clearing=1.
- First clear pixel (0,0) appears on the first rising edge after reset_n deasserts.
- Pixel latency is 1 cycle: the drawer pixel sampled on the edge where gnt[g]=1 appears on vga_* immediately after that edge.
- Arbitration costs 1 IDLE cycle between consecutive grants and between a grant and a clear. vga_plot=0 in that cycle.
- A symbol of N pixels occupies 1 IDLE cycle plus N GRANT cycles.
- gnt changes only on clk edges; it is decoded from registered state and g.
- reset_n asserted mid-grant or mid-clear: all outputs return to reset values immediately (asynchronous), then the machine restarts with CLEAR.

## Test plan
- Reset release, no requests -> 19200 consecutive vga_plot=1 cycles sweeping (0,0)..(159,119) in raster order with colour 000; then clearing=0, busy=0.
- After the clear, req[2]=1 with a 36-pixel symbol at base (40,30), plast on pixel 36 -> 1 gap cycle, then gnt=0100 for 36 cycles, 36 plots each one cycle after its gnt edge, then gnt=0.
- req=1111 held with 3-pixel symbols -> grant order 0,1,2,3,0. Each grant is 3 cycles, separated by 1 gap cycle.
- clear_req pulsed mid-grant of drawer 1 -> drawer 1 completes all of its pixels, then 1 gap cycle, then a full clear. No second clear is triggered by the same pulse.
- req[3] drops mid-symbol after 5 pixels -> exactly 5 plots, then IDLE, rr_ptr=3, and drawer 0 is preferred next.
- reset_n pulsed low mid-grant -> vga_plot=0 and gnt=0 asynchronously, and a new full clear starts after release.

Source files
------------

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
//   Shares the single VGA adapter pixel-write port between four symbol
//   drawers and a full-screen clear engine. Drawers are granted round-robin
//   and keep the grant for a whole symbol; the selected pixel is registered
//   onto the adapter inputs one cycle after it is accepted. A clear runs
//   after reset and whenever clear_req is seen outside a running clear.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_CLEAR | sweep every pixel in raster order with CLEAR_COLOUR
//   S_IDLE  | one arbitration cycle, nothing plotted
//   S_GRANT | drawer r_g owns the port until its last pixel or abort
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   clear_req             request a full-screen clear (pulse)
//   req[3:0]              per-drawer request, held until last pixel accepted
//   px/py/pcolour         packed per-drawer pixel (8/7/3 bits per drawer)
//   plast[3:0]            drawer's current pixel ends its symbol
//   gnt[3:0]              one-hot grant, decoded from registered state
//   vga_x/y/colour/plot   registered adapter write port
//   busy, clearing        state != S_IDLE, state == S_CLEAR
module vga_draw_arbiter #(
  parameter logic [2:0] CLEAR_COLOUR = 3'b000,
  parameter int         X_MAX        = 160,
  parameter int         Y_MAX        = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_req,
  input  logic [3:0]  req,
  input  logic [31:0] px,
  input  logic [27:0] py,
  input  logic [11:0] pcolour,
  input  logic [3:0]  plast,
  output logic [3:0]  gnt,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        clearing
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_GRANT} state_t;

  state_t      r_state;
  logic [7:0]  r_cx;
  logic [6:0]  r_cy;
  logic [1:0]  r_rr_ptr;
  logic [1:0]  r_g;
  logic        r_clear_pending;
  logic [7:0]  r_vga_x;
  logic [6:0]  r_vga_y;
  logic [2:0]  r_vga_colour;
  logic        r_vga_plot;

  logic [1:0]  w_winner;
  logic [1:0]  w_idx;
  logic        w_found;
  logic        w_any_req;
  logic [7:0]  w_sel_x;
  logic [6:0]  w_sel_y;
  logic [2:0]  w_sel_colour;
  logic        w_sel_req;
  logic        w_sel_last;

  // Round-robin search starts just after the last drawer served; the k=4
  // step wraps back onto r_rr_ptr itself so it is considered last.
  always_comb begin
    w_any_req = |req;
    w_winner  = r_rr_ptr;
    w_idx     = r_rr_ptr;
    w_found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_x      = px[7:0];
    w_sel_y      = py[6:0];
    w_sel_colour = pcolour[2:0];
    case (r_g)
      2'd1: begin
        w_sel_x = px[15:8];  w_sel_y = py[13:7];  w_sel_colour = pcolour[5:3];
      end
      2'd2: begin
        w_sel_x = px[23:16]; w_sel_y = py[20:14]; w_sel_colour = pcolour[8:6];
      end
      2'd3: begin
        w_sel_x = px[31:24]; w_sel_y = py[27:21]; w_sel_colour = pcolour[11:9];
      end
      default: ;
    endcase
    w_sel_req  = req[r_g];
    w_sel_last = plast[r_g];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_CLEAR;
      r_cx            <= '0;
      r_cy            <= '0;
      r_rr_ptr        <= 2'd3;
      r_g             <= '0;
      r_clear_pending <= 1'b0;
      r_vga_x         <= '0;
      r_vga_y         <= '0;
      r_vga_colour    <= '0;
      r_vga_plot      <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_vga_x      <= r_cx;
          r_vga_y      <= r_cy;
          r_vga_colour <= CLEAR_COLOUR;
          r_vga_plot   <= 1'b1;
          if (r_cx == 8'(X_MAX - 1)) begin
            r_cx <= '0;
            if (r_cy == 7'(Y_MAX - 1)) begin
              r_cy    <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cy <= r_cy + 7'd1;
            end
          end else begin
            r_cx <= r_cx + 8'd1;
          end
        end
        S_IDLE: begin
          r_vga_plot <= 1'b0;
          if (clear_req || r_clear_pending) begin
            r_clear_pending <= 1'b0;
            r_state         <= S_CLEAR;
          end else if (w_any_req) begin
            r_g     <= w_winner;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_vga_x      <= w_sel_x;
          r_vga_y      <= w_sel_y;
          r_vga_colour <= w_sel_colour;
          // A dropped request is an abort: nothing is plotted that cycle.
          r_vga_plot   <= w_sel_req;
          if (clear_req) r_clear_pending <= 1'b1;
          if (!w_sel_req || w_sel_last) begin
            r_rr_ptr <= r_g;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign gnt        = (r_state == S_GRANT) ? (4'b0001 << r_g) : 4'b0000;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign busy       = (r_state != S_IDLE);
  assign clearing   = (r_state == S_CLEAR);

endmodule

// File: tb/tb_vga_draw_arbiter.sv
module tb_vga_draw_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        clear_req = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] px = '0;
  logic [27:0] py = '0;
  logic [11:0] pcolour = '0;
  logic [3:0]  plast = '0;
  logic [3:0]  gnt;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        clearing;

  int n_checks = 0;
  int n_errors = 0;
  int plot_cnt = 0;

  logic [17:0] exp_q[$];

  // drawer models
  int         d_len[4]   = '{default: 0};
  int         d_cnt[4]   = '{default: 0};
  int         d_abort[4] = '{default: -1};
  logic       d_act[4]   = '{default: 1'b0};
  logic [7:0] d_bx[4]    = '{default: 8'd0};
  logic [6:0] d_by[4]    = '{default: 7'd0};
  logic [2:0] d_col[4]   = '{default: 3'd0};
  logic [3:0] g_s;

  vga_draw_arbiter dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .req(req),
    .px(px), .py(py), .pcolour(pcolour), .plast(plast), .gnt(gnt),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .clearing(clearing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_drawers();
    for (int i = 0; i < 4; i++) begin
      int p;
      p = d_cnt[i];
      req[i] = d_act[i] && (p < d_len[i]) && !(d_abort[i] >= 0 && p >= d_abort[i]);
      px[8*i +: 8] = d_bx[i] + 8'(p % 6);
      py[7*i +: 7] = d_by[i] + 7'(p / 6);
      pcolour[3*i +: 3] = d_col[i];
      plast[i] = (p == d_len[i] - 1);
    end
  endtask

  task automatic start_sym(input int i, input int len, input int abort_at,
                           input logic [7:0] bx, input logic [6:0] by, input logic [2:0] col);
    d_len[i] = len; d_abort[i] = abort_at; d_bx[i] = bx; d_by[i] = by;
    d_col[i] = col; d_cnt[i] = 0; d_act[i] = 1'b1;
    drive_drawers();
  endtask

  task automatic push_sym(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] col, input int n);
    for (int p = 0; p < n; p++) begin
      logic [7:0] xx;
      logic [6:0] yy;
      xx = bx + 8'(p % 6);
      yy = by + 7'(p / 6);
      exp_q.push_back({xx, yy, col});
    end
  endtask

  task automatic push_clear();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        exp_q.push_back({8'(x), 7'(y), 3'b000});
  endtask

  // wait for a grant, check who and the gap before it, then time its length
  task automatic run_grant(input logic [3:0] exp_g, input int exp_len, input int exp_gap, input int pulse_at);
    int w;
    int len;
    w = 0;
    len = 0;
    while (gnt == 4'b0 && w < 50) begin @(negedge clk); w++; end
    chk("grant_gap", w, exp_gap);
    chk("grant_who", {28'd0, gnt}, {28'd0, exp_g});
    while (gnt == exp_g && len < 100) begin
      clear_req = (len == pulse_at);
      @(negedge clk);
      len++;
    end
    clear_req = 1'b0;
    chk("grant_len", len, exp_len);
  endtask

  task automatic wait_clear_done(input string tag);
    int w;
    w = 0;
    while (clearing && w < 20000) begin @(negedge clk); w++; end
    chk(tag, w, 19200);
  endtask

  // drawers advance on edges where they were granted with a live request
  always begin
    @(negedge clk);
    g_s = gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (g_s[i] && req[i]) d_cnt[i]++;
    drive_drawers();
  end

  // scoreboard: every plot must match the next expected pixel
  always @(negedge clk) begin
    if (reset_n && vga_plot) begin
      logic [17:0] e;
      plot_cnt++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3ffff;
      chk("pixel", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, e});
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    #2 reset_n = 1'b0;
    #3;
    chk("rst_x", {24'd0, vga_x}, 0);
    chk("rst_y", {25'd0, vga_y}, 0);
    chk("rst_colour", {29'd0, vga_colour}, 0);
    chk("rst_plot", {31'd0, vga_plot}, 0);
    chk("rst_gnt", {28'd0, gnt}, 0);
    chk("rst_busy", {31'd0, busy}, 1);
    chk("rst_clearing", {31'd0, clearing}, 1);
    repeat (3) @(negedge clk);

    // power-up clear
    push_clear();
    reset_n = 1'b1;
    wait_clear_done("clear1_cycles");
    @(negedge clk);
    chk("clear1_plots", plot_cnt, 19200);
    chk("clear1_q_empty", exp_q.size(), 0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_plot", {31'd0, vga_plot}, 0);

    // single 36-pixel symbol on drawer 2
    base = plot_cnt;
    push_sym(8'd40, 7'd30, 3'd5, 36);
    start_sym(2, 36, -1, 8'd40, 7'd30, 3'd5);
    run_grant(4'b0100, 36, 1, -1);
    @(negedge clk);
    chk("sym2_plots", plot_cnt - base, 36);
    chk("sym2_q_empty", exp_q.size(), 0);

    // drawer 3 aborts after 5 pixels
    base = plot_cnt;
    push_sym(8'd100, 7'd10, 3'd3, 5);
    start_sym(3, 10, 5, 8'd100, 7'd10, 3'd3);
    run_grant(4'b1000, 6, 1, -1);
    @(negedge clk);
    chk("abort_plots", plot_cnt - base, 5);
    chk("abort_busy", {31'd0, busy}, 0);

    // all four requesting: 0 preferred after 3, then 1,2,3,0
    base = plot_cnt;
    push_sym(8'd10, 7'd50, 3'd1, 3);
    push_sym(8'd20, 7'd60, 3'd2, 3);
    push_sym(8'd30, 7'd70, 3'd4, 3);
    push_sym(8'd50, 7'd80, 3'd6, 3);
    push_sym(8'd70, 7'd90, 3'd7, 3);
    start_sym(0, 3, -1, 8'd10, 7'd50, 3'd1);
    start_sym(1, 3, -1, 8'd20, 7'd60, 3'd2);
    start_sym(2, 3, -1, 8'd30, 7'd70, 3'd4);
    start_sym(3, 3, -1, 8'd50, 7'd80, 3'd6);
    run_grant(4'b0001, 3, 1, -1);
    start_sym(0, 3, -1, 8'd70, 7'd90, 3'd7);
    run_grant(4'b0010, 3, 1, -1);
    run_grant(4'b0100, 3, 1, -1);
    run_grant(4'b1000, 3, 1, -1);
    run_grant(4'b0001, 3, 1, -1);
    @(negedge clk);
    chk("rr_plots", plot_cnt - base, 15);
    chk("rr_q_empty", exp_q.size(), 0);

    // clear_req pulsed mid-grant: symbol completes, gap, one full clear
    base = plot_cnt;
    push_sym(8'd120, 7'd100, 3'd2, 8);
    push_clear();
    start_sym(1, 8, -1, 8'd120, 7'd100, 3'd2);
    run_grant(4'b0010, 8, 1, 3);
    chk("midclr_gap_clearing", {31'd0, clearing}, 0);
    @(negedge clk);
    chk("midclr_start_clearing", {31'd0, clearing}, 1);
    chk("midclr_gap_plot", {31'd0, vga_plot}, 0);
    chk("midclr_sym_plots", plot_cnt - base, 8);
    wait_clear_done("clear2_cycles");
    @(negedge clk);
    chk("clear2_plots", plot_cnt - base, 19208);
    repeat (5) @(negedge clk);
    chk("no_second_clear", {31'd0, clearing}, 0);
    chk("clear2_q_empty", exp_q.size(), 0);

    // reset pulsed mid-grant
    base = plot_cnt;
    push_sym(8'd5, 7'd5, 3'd6, 4);
    start_sym(1, 20, -1, 8'd5, 7'd5, 3'd6);
    begin
      int w;
      w = 0;
      while (gnt == 4'b0 && w < 50) begin @(negedge clk); w++; end
      chk("rstg_who", {28'd0, gnt}, 4'b0010);
    end
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rstg_plot", {31'd0, vga_plot}, 0);
    chk("rstg_gnt", {28'd0, gnt}, 0);
    chk("rstg_x", {24'd0, vga_x}, 0);
    chk("rstg_clearing", {31'd0, clearing}, 1);
    for (int i = 0; i < 4; i++) d_act[i] = 1'b0;
    drive_drawers();
    push_clear();
    @(negedge clk);
    reset_n = 1'b1;
    wait_clear_done("clear3_cycles");
    @(negedge clk);
    chk("rstg_plots", plot_cnt - base, 19204);
    chk("rstg_q_empty", exp_q.size(), 0);
    chk("final_busy", {31'd0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
